// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : One-bit-per-clock 8E1/8O1 serial receiver with FWFT frame FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter bit PARITY_ODD = 1'b0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    output logic [7:0] DataOut,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       DataValid,
    input  logic       DataReady,
    output logic       Overrun,
    input  logic       OverrunClr,
    output logic       Busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } state_t;

    logic       rx_meta;
    logic       rx_s;
    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic [2:0] cnt_nx;
    logic [7:0] shift;
    logic [7:0] shift_nx;
    logic       perr;
    logic       perr_nx;
    logic       push;
    logic [9:0] push_entry;

    // Synchronizer flops reset to the idle line level so reset never fakes a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            shift <= 8'd0;
            perr  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shift <= shift_nx;
            perr  <= perr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        shift_nx   = shift;
        perr_nx    = perr;
        push       = 1'b0;
        push_entry = {~rx_s, perr, shift};
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = DATA;
                    cnt_nx   = 3'd0;
                end
            end
            DATA: begin
                shift_nx[cnt] = rx_s;
                cnt_nx        = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_nx = PARITY;
                end
            end
            PARITY: begin
                perr_nx  = rx_s ^ (^shift) ^ PARITY_ODD;
                state_nx = STOP;
            end
            STOP: begin
                push     = 1'b1;
                state_nx = rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                if (rx_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    // Frame FIFO: pointers carry one wrap bit to distinguish full from empty
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        wr_en;
    logic        ovr_set;
    logic [9:0]  head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign pop     = !empty && DataReady;
    assign wr_en   = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            Overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovr_set) begin
                Overrun <= 1'b1;
            end else if (OverrunClr) begin
                Overrun <= 1'b0;
            end
        end
    end

    assign head                            = mem[rd_ptr[AW-1:0]];
    assign DataValid                       = !empty;
    assign {FrameErr, ParityErr, DataOut}  = empty ? 10'd0 : head;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed, table-driven self-checking bench for uart_rx
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst;
    logic       Rx;
    logic [7:0] DataOut;
    logic       ParityErr;
    logic       FrameErr;
    logic       DataValid;
    logic       DataReady;
    logic       Overrun;
    logic       OverrunClr;
    logic       Busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx #(.PARITY_ODD(1'b0), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .Rx        (Rx),
        .DataOut   (DataOut),
        .ParityErr (ParityErr),
        .FrameErr  (FrameErr),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .Overrun   (Overrun),
        .OverrunClr(OverrunClr),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        tick(1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic pop_one();
        DataReady = 1'b1;
        tick(1);
        DataReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // data, line parity bit, stop bit, expected perr, expected ferr
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h37, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1};

        rst        = 1'b1;
        Rx         = 1'b1;
        DataReady  = 1'b0;
        OverrunClr = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset_valid",   DataValid, 0);
        check("reset_busy",    Busy, 0);
        check("reset_overrun", Overrun, 0);
        check("reset_data",    DataOut, 0);
        check("reset_perr",    ParityErr, 0);
        check("reset_ferr",    FrameErr, 0);
        tick(3);
        rst = 1'b1;
        tick(2);

        DataReady = 1'b1;
        tick(3);
        DataReady = 1'b0;
        check("empty_pop_valid", DataValid, 0);

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
            Rx = 1'b1;
            tick(1);
            check("latency_early", DataValid, 0);
            tick(1);
            check("latency_valid", DataValid, 1);
            check("vec_data", DataOut, vecs[v].data);
            check("vec_perr", ParityErr, vecs[v].exp_perr);
            check("vec_ferr", FrameErr, vecs[v].exp_ferr);
            tick(2);
            check("hold_data", DataOut, vecs[v].data);
            pop_one();
            check("vec_popped", DataValid, 0);
        end

        // Framing error followed by a long break
        send_frame(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'b0);
        check("break_busy", Busy, 1);
        Rx = 1'b1;
        tick(4);
        check("break_idle", Busy, 0);
        check("break_valid", DataValid, 1);
        check("break_data", DataOut, 8'h3C);
        check("break_ferr", FrameErr, 1);
        check("break_perr", ParityErr, 0);
        pop_one();
        check("break_single", DataValid, 0);

        // Overrun: third back-to-back frame is dropped
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        Rx = 1'b1;
        tick(3);
        check("ovr_set", Overrun, 1);
        check("ovr_head0", DataOut, 8'h11);
        pop_one();
        check("ovr_head1", DataOut, 8'h22);
        pop_one();
        check("ovr_empty", DataValid, 0);
        check("ovr_sticky", Overrun, 1);
        OverrunClr = 1'b1;
        tick(1);
        OverrunClr = 1'b0;
        check("ovr_clear", Overrun, 0);

        // Full FIFO with pop in the same cycle as the push
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        Rx = 1'b1;
        tick(3);
        check("fullpop_head0", DataOut, 8'h11);
        send_frame(8'h33, 1'b0, 1'b1);
        Rx = 1'b1;
        tick(1);
        DataReady = 1'b1;
        tick(1);
        DataReady = 1'b0;
        check("fullpop_no_ovr", Overrun, 0);
        check("fullpop_head1", DataOut, 8'h22);
        pop_one();
        check("fullpop_head2", DataOut, 8'h33);
        pop_one();
        check("fullpop_empty", DataValid, 0);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("midrst_busy_before", Busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_busy_during", Busy, 0);
        check("midrst_valid_during", DataValid, 0);
        Rx = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(3);
        check("midrst_idle", Busy, 0);
        check("midrst_no_frame", DataValid, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        Rx = 1'b1;
        tick(2);
        check("midrst_valid", DataValid, 1);
        check("midrst_data", DataOut, 8'h5A);
        pop_one();
        check("midrst_single", DataValid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
